// File: rtl/single_port_sync_ram_pkg.sv
// Shared defaults and word type for the single-port synchronous RAM.
package single_port_sync_ram_pkg;

  localparam int unsigned SPRAM_ADDR_WIDTH = 4;
  localparam int unsigned SPRAM_DATA_WIDTH = 16;
  localparam int unsigned SPRAM_DEPTH      = 16;

  typedef logic [SPRAM_DATA_WIDTH-1:0] spram_word_t;

endpackage

// File: rtl/spram_array.sv
// Storage array for the single-port RAM: async clear, write port and registered read port.
module spram_array
  import single_port_sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SPRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SPRAM_DATA_WIDTH,
  parameter int unsigned DEPTH      = SPRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  cs,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rd_q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;

  // Addresses beyond DEPTH are dropped on write and read back as zero.
  assign in_range = (32'(addr) < DEPTH);

  // Write port; reset clears every word so an aborted access leaves zero behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (cs && we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port; holds its value on writes and deselected cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (cs && !we) begin
      rd_q <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM on a shared tristate data bus.
// Optional macro SPRAM_CONFLICT_EN adds a registered 'conflict' flag for cs & we & oe.
module single_port_sync_ram
  import single_port_sync_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SPRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SPRAM_DATA_WIDTH,
  parameter int unsigned DEPTH      = SPRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
`ifdef SPRAM_CONFLICT_EN
  ,
  output logic                  conflict
`endif
);

  logic [DATA_WIDTH-1:0] rd_q;
  logic                  drive;

  spram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (data),
    .cs    (cs),
    .we    (we),
    .rd_q  (rd_q)
  );

  // Never drive while we=1 so the writing master sees no contention.
  assign drive = cs & oe & ~we;
  assign data  = drive ? rd_q : {DATA_WIDTH{1'bz}};

`ifdef SPRAM_CONFLICT_EN
  // Flags a master that writes while also enabling the RAM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else begin
      conflict <= cs & we & oe;
    end
  end
`endif

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Self-checking bench for single_port_sync_ram against an array-based reference model.
module tb_single_port_sync_ram;
  import single_port_sync_ram_pkg::*;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic [3:0]  addr   = '0;
  logic        cs     = 1'b0;
  logic        we     = 1'b0;
  logic        oe     = 1'b0;
  spram_word_t m_data = '0;
  logic        m_en   = 1'b0;
  wire  [15:0] data;
`ifdef SPRAM_CONFLICT_EN
  logic        conflict;
  logic        exp_conflict;
`endif

  spram_word_t model [16];
  spram_word_t rd_model;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Bus master side of the shared net.
  assign data = m_en ? m_data : 16'hzzzz;

  single_port_sync_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data     (data),
    .cs       (cs),
    .we       (we),
    .oe       (oe)
`ifdef SPRAM_CONFLICT_EN
    ,
    .conflict (conflict)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = '0;
    rd_model = '0;
  endtask

  // One access: apply inputs, take an edge, update the model, check the bus.
  task automatic cycle(input logic c, input logic w, input logic o, input logic [3:0] a,
                       input spram_word_t d, input string tag);
    cs = c; we = w; oe = o; addr = a; m_data = d; m_en = w;
    @(posedge clk);
    #1;
    if (c && w) model[a] = d;
    else if (c) rd_model = model[a];
`ifdef SPRAM_CONFLICT_EN
    exp_conflict = c & w & o;
    check({tag, "_conflict"}, {15'd0, conflict}, {15'd0, exp_conflict});
`endif
    if (c && o && !w) check(tag, data, rd_model);
    else if (w) check({tag, "_wbus"}, data, d);
  endtask

  spram_word_t wtab [16];

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    cs = 1'b1; oe = 1'b1; we = 1'b0;
    #1 check("reset_bus", data, 16'h0000);
`ifdef SPRAM_CONFLICT_EN
    check("reset_conflict", {15'd0, conflict}, 16'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Fresh RAM reads zero everywhere.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i), '0, "reset_read");

    // Fill all words, then read them back.
    wtab[0] = 16'h3524;
    wtab[1] = 16'h5E81;
    for (int i = 2; i < 16; i++) wtab[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 4'(i), wtab[i], "fill");
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 4'(i), '0, "readback");
      check("readback_tab", data, wtab[i]);
    end

    // Bus release: RAM must float under oe=0, cs=0 and we=1.
    cycle(1'b1, 1'b0, 1'b0, 4'd3, '0, "rel_oe");
    m_data = 16'hBEEF; m_en = 1'b1;
    #1 check("release_oe0", data, 16'hBEEF);
    cycle(1'b0, 1'b0, 1'b1, 4'd3, '0, "rel_cs");
    m_data = 16'hBEEF; m_en = 1'b1;
    #1 check("release_cs0", data, 16'hBEEF);
    cycle(1'b1, 1'b1, 1'b1, 4'd4, 16'hBEEF, "release_we1");

    // Hold: rd_q survives deselected cycles, then a read recaptures.
    cycle(1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, "hold_wr");
    cycle(1'b1, 1'b0, 1'b1, 4'd5, '0, "hold_rd");
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 4'(k * 3 + 1), '0, "hold_idle");
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = 4'd9;
    #1 check("hold_value", data, 16'h1234);
    cycle(1'b1, 1'b0, 1'b1, 4'd9, '0, "hold_recapture");

    // Back-to-back writes to one address: last one wins.
    cycle(1'b1, 1'b1, 1'b0, 4'd6, 16'h1111, "ww1");
    cycle(1'b1, 1'b1, 1'b0, 4'd6, 16'h2222, "ww2");
    cycle(1'b1, 1'b0, 1'b1, 4'd6, '0, "ww_read");
    check("last_write_wins", data, 16'h2222);

    // Async reset between edges clears bus and array without a clock.
    cycle(1'b1, 1'b1, 1'b0, 4'd7, 16'hA5A5, "ar_wr");
    cycle(1'b1, 1'b0, 1'b1, 4'd7, '0, "ar_rd");
    check("ar_before", data, 16'hA5A5);
    #1 rst_n = 1'b0;
    #1 check("async_reset_bus", data, 16'h0000);
`ifdef SPRAM_CONFLICT_EN
    check("async_reset_conflict", {15'd0, conflict}, 16'd0);
`endif
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 4'd7, '0, "ar_after");
    check("ar_after_zero", data, 16'h0000);

    // Protocol-error write still stores; flag clears on the next clean edge.
    cycle(1'b1, 1'b1, 1'b1, 4'd2, 16'hCAFE, "conf_wr");
    cycle(1'b1, 1'b0, 1'b1, 4'd2, '0, "conf_rd");
    check("conf_stored", data, 16'hCAFE);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/single_port_sync_ram.md
# single_port_sync_ram

Synchronous single-port RAM with a shared bidirectional data bus, chip select, write enable and output enable. One clock edge per access: writes commit on the rising edge; reads are registered and driven onto the tristate bus only while the bus is granted to the RAM. It is a local scratch store for a bus master that owns the same `data` net and releases it when reading.

## Interface
- `ADDR_WIDTH`, default 4: address bits.
- `DATA_WIDTH`, default 16: word width.
- `DEPTH`, default 16 (`2**ADDR_WIDTH`): number of words. Addresses at or above `DEPTH` are ignored on write and read as 0.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `addr`, input, `ADDR_WIDTH`: word address.
- `data`, inout, `DATA_WIDTH`: shared bus. Written into the RAM on a write; driven by the RAM on a read; high-Z otherwise.
- `cs`, input, 1: chip select, active-high.
- `we`, input, 1: write enable, active-high; 0 means read.
- `oe`, input, 1: output enable, active-high; gates the tristate driver.
- `conflict`, output, 1: present only with `SPRAM_CONFLICT_EN`; see Configuration.

## Operation
- Write: on a rising `clk` edge with `cs=1, we=1`, `mem[addr] <= data`. `oe` is ignored for the write itself.
- Read capture: on a rising `clk` edge with `cs=1, we=0`, `rd_q <= mem[addr]`.
- `rd_q` holds its value in all other cycles, including `cs=0` and writes.
- Bus drive: `data = rd_q` when `cs & oe & ~we`, combinational enable; otherwise `data` is all-Z.
- The RAM never drives `data` while `we=1`. This guarantees no contention with the writing master.
- Reset (`rst_n=0`) takes effect immediately, asynchronously:
  - all `DEPTH` words cleared to 0;
  - `rd_q` = 0;
  - `conflict` = 0.
- Reset release is synchronous to `clk`. First access is allowed on the first rising edge after `rst_n` goes high.
- Reset asserted mid-access aborts that access. The addressed word reads 0 afterwards.
- Write to the same address on consecutive edges: last write wins.
- Read-after-write to the same address on the next edge returns the new data. There is no same-edge bypass, because an edge is either a read or a write.

## Timing
- Write latency: data is stored at the sampling edge and is readable from the following edge.
- Read latency 1: `addr` sampled at edge N gives `rd_q` valid after edge N. It appears on `data` once `cs & oe & ~we` holds.
- Output enable is combinational. `data` goes valid or Z within the same cycle that `oe`, `cs` or `we` changes, with no clock needed.
- `rd_q` and `mem` are the only state. There is no FSM.

## Configuration
- `SPRAM_CONFLICT_EN` defined:
  - adds the registered `conflict` output;
  - on each rising edge, `conflict <= cs & we & oe` (master writing while enabling RAM output, a protocol error);
  - the write still occurs and the RAM still does not drive.
- Not defined: no `conflict` port and no related logic.

## Structure
- Package `single_port_sync_ram_pkg` holds:
  - default constants `SPRAM_ADDR_WIDTH=4`, `SPRAM_DATA_WIDTH=16`, `SPRAM_DEPTH=16`;
  - a `spram_word_t` typedef built from the data width.
- One natural sub-module, `spram_array`. It holds the storage array, the reset clear, the write port and the registered read port (`rd_q`).
- The top level keeps the tristate driver and the optional conflict flag.

## Test plan
- Reset then read: after `rst_n` is pulsed low, read addresses 0..15 with `cs=1, we=0, oe=1`. `data` = 16'h0000 one cycle after each address.
- Write then read back all words: write `16'h3524` to address 0, `16'h5E81` to address 1, and so on through address 15 with `cs=1, we=1, oe=0`. Read 0..15 and each word returns one cycle after its address is sampled.
- Bus release: with `oe=0`, or `cs=0`, or `we=1`, `data` is Z from the RAM side. A master driving `16'hBEEF` sees no contention (no X).
- Hold: read address 5 (value `16'h1234`), then drop `cs` for 3 cycles while toggling `addr`. Raising `oe` with `cs=1, we=0` shows `16'h1234` until the next edge recaptures.
- Async reset mid-sequence: write `16'hA5A5` to address 7, then assert `rst_n=0` between edges. `data` becomes 0 without waiting for a clock edge, and address 7 later reads `16'h0000`.
- With `SPRAM_CONFLICT_EN`: drive `cs=we=oe=1` for one edge and `conflict` is 1 after that edge. The write to `addr` still stores, and `conflict` returns to 0 on the next non-conflicting edge.
